// File: rtl/s27_scan_array.sv
// Array of N_CH s27 benchmark channels whose 3*N_CH state flops form one scan chain,
// with a shift -> launch -> capture controller for launch-on-capture delay-test runs.
// Latency: DONE rises 3*N_CH+2 edges after START is sampled; no backpressure (START ignored when not IDLE).
//
// Ports:
//   CLK, RSTN        rising-edge clock, asynchronous active-low reset
//   G0..G3 [N_CH]    per-channel primary inputs (bit c = channel c)
//   FREEZE           holds the flops while the controller is IDLE
//   START            requests one shift/launch/capture sequence (sampled in IDLE only)
//   SI / SO          scan-in / scan-out (SO = last chain flop)
//   G17 [N_CH]       per-channel combinational output
//   STATE_Q [3*N_CH] flop readback: [3c]=G5, [3c+1]=G6, [3c+2]=G7 of channel c
//   BUSY, DONE       sequence in progress / one-cycle completion pulse
//   MISR_SIG [16]    capture signature; only built when S27_SCAN_ARRAY_MISR_EN is defined, else 0
module s27_scan_array #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 6
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic [N_CH-1:0]     G0,
    input  logic [N_CH-1:0]     G1,
    input  logic [N_CH-1:0]     G2,
    input  logic [N_CH-1:0]     G3,
    input  logic                FREEZE,
    input  logic                START,
    input  logic                SI,
    output logic [N_CH-1:0]     G17,
    output logic                SO,
    output logic [3*N_CH-1:0]   STATE_Q,
    output logic                BUSY,
    output logic                DONE,
    output logic [15:0]         MISR_SIG
);

    localparam int CHAIN_LEN = 3 * N_CH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LAUNCH,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t                 fsm_q, fsm_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0]   flops_q, flops_d;
    logic [CHAIN_LEN-1:0]   func_nxt;

    // Per-channel s27 gate network, evaluated bitwise across all channels.
    logic [N_CH-1:0] g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16;

    always_comb begin
        g5 = '0;
        g6 = '0;
        g7 = '0;
        for (int c = 0; c < N_CH; c++) begin
            g5[c] = flops_q[3*c];
            g6[c] = flops_q[3*c+1];
            g7[c] = flops_q[3*c+2];
        end
    end

    assign g14 = ~G0;
    assign g12 = ~(G1 | g7);
    assign g13 = ~(G2 | g12);
    assign g8  = g14 & g6;
    assign g15 = g12 | g8;
    assign g16 = G3 | g8;
    assign g9  = ~(g16 & g15);
    assign g11 = ~(g5 | g9);
    assign g10 = ~(g14 | g11);
    assign G17 = ~g11;

    always_comb begin
        func_nxt = '0;
        for (int c = 0; c < N_CH; c++) begin
            func_nxt[3*c]   = g10[c];
            func_nxt[3*c+1] = g11[c];
            func_nxt[3*c+2] = g13[c];
        end
    end

    // Controller and flop next-state. The START-accepting edge leaves the
    // flops untouched so the chain starts shifting from the IDLE contents.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        flops_d = flops_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (START) begin
                    fsm_d = ST_SHIFT;
                    cnt_d = CNT_W'(CHAIN_LEN - 1);
                end else if (!FREEZE) begin
                    flops_d = func_nxt;
                end
            end
            ST_SHIFT: begin
                flops_d = {flops_q[CHAIN_LEN-2:0], SI};
                if (cnt_q == '0) begin
                    fsm_d = ST_LAUNCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LAUNCH: begin
                flops_d = func_nxt;
                fsm_d   = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                flops_d = func_nxt;
                fsm_d   = ST_DONE;
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fsm_q   <= ST_IDLE;
            cnt_q   <= '0;
            flops_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            flops_q <= flops_d;
        end
    end

    assign STATE_Q = flops_q;
    assign SO      = flops_q[CHAIN_LEN-1];
    assign BUSY    = (fsm_q == ST_SHIFT) || (fsm_q == ST_LAUNCH) || (fsm_q == ST_CAPTURE);
    assign DONE    = (fsm_q == ST_DONE);

`ifdef S27_SCAN_ARRAY_MISR_EN
    logic [15:0] misr_q, misr_d;
    logic [15:0] g17_ext;

    always_comb begin
        g17_ext = '0;
        g17_ext[N_CH-1:0] = G17;
    end

    // Signature folds the capture-cycle outputs; a fresh sequence starts from zero.
    always_comb begin
        misr_d = misr_q;
        if (fsm_q == ST_IDLE && START) begin
            misr_d = '0;
        end else if (fsm_q == ST_CAPTURE) begin
            misr_d = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h002D : 16'h0000) ^ g17_ext;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            misr_q <= '0;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign MISR_SIG = misr_q;
`else
    assign MISR_SIG = 16'h0000;
`endif

endmodule

// File: tb/tb_s27_scan_array.sv
// Directed bench for s27_scan_array: one 2-channel and one 1-channel instance.
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: none; every wait is a fixed number of edges.
module tb_s27_scan_array;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // 2-channel instance
    logic       a_rstn, a_freeze, a_start, a_si;
    logic [1:0] a_g0, a_g1, a_g2, a_g3, a_g17;
    logic       a_so, a_busy, a_done;
    logic [5:0] a_state;
    logic [15:0] a_misr;

    // 1-channel instance
    logic       b_rstn, b_freeze, b_start, b_si;
    logic [0:0] b_g0, b_g1, b_g2, b_g3, b_g17;
    logic       b_so, b_busy, b_done;
    logic [2:0] b_state;
    logic [15:0] b_misr;

    s27_scan_array #(.N_CH(2), .CNT_W(6)) dut_a (
        .CLK(clk_i), .RSTN(a_rstn),
        .G0(a_g0), .G1(a_g1), .G2(a_g2), .G3(a_g3),
        .FREEZE(a_freeze), .START(a_start), .SI(a_si),
        .G17(a_g17), .SO(a_so), .STATE_Q(a_state),
        .BUSY(a_busy), .DONE(a_done), .MISR_SIG(a_misr)
    );

    s27_scan_array #(.N_CH(1), .CNT_W(6)) dut_b (
        .CLK(clk_i), .RSTN(b_rstn),
        .G0(b_g0), .G1(b_g1), .G2(b_g2), .G3(b_g3),
        .FREEZE(b_freeze), .START(b_start), .SI(b_si),
        .G17(b_g17), .SO(b_so), .STATE_Q(b_state),
        .BUSY(b_busy), .DONE(b_done), .MISR_SIG(b_misr)
    );

    int n_checks = 0;
    int n_errors = 0;

`ifdef S27_SCAN_ARRAY_MISR_EN
    localparam logic [15:0] MISR_EXP = 16'h0003;
`else
    localparam logic [15:0] MISR_EXP = 16'h0000;
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    int done_cnt;
    int done_edge;

    initial begin
        a_rstn = 1'b0; a_freeze = 1'b0; a_start = 1'b0; a_si = 1'b0;
        a_g0 = '0; a_g1 = '0; a_g2 = '0; a_g3 = '0;
        b_rstn = 1'b0; b_freeze = 1'b0; b_start = 1'b0; b_si = 1'b0;
        b_g0 = '0; b_g1 = '0; b_g2 = '0; b_g3 = '0;

        // Reset values while RSTN is held low (before any clock edge)
        #3;
        check_val("rst_state", 32'(a_state), 32'h00);
        check_val("rst_g17",   32'(a_g17),   32'h3);
        check_val("rst_busy",  32'(a_busy),  32'h0);
        check_val("rst_done",  32'(a_done),  32'h0);
        check_val("rst_so",    32'(a_so),    32'h0);
        check_val("rst_misr",  32'(a_misr),  32'h0);
        check_val("rst_b_state", 32'(b_state), 32'h0);
        #5;
        a_rstn = 1'b1;
        b_rstn = 1'b1;

        // Functional step, 1 channel: G0=1 from state 0 -> G5 set
        b_g0 = 1'b1;
        tick();
        check_val("func_step", 32'(b_state), 32'h1);

        // Same step with FREEZE held: flops stay at 0
        b_rstn = 1'b0;
        #2;
        check_val("func_rst_b", 32'(b_state), 32'h0);
        b_rstn = 1'b1;
        b_freeze = 1'b1;
        tick();
        check_val("freeze_hold1", 32'(b_state), 32'h0);
        tick();
        check_val("freeze_hold2", 32'(b_state), 32'h0);
        b_freeze = 1'b0;
        tick();
        check_val("unfreeze_step", 32'(b_state), 32'h1);

        // Scan-out: state 001 (stable with G0=1), shift zeros in; SO = 0,0,1
        b_start = 1'b1;
        b_si    = 1'b0;
        tick();                             // accepting edge
        b_start = 1'b0;
        check_val("scan_busy", 32'(b_busy), 32'h1);
        check_val("scan_hold", 32'(b_state), 32'h1);
        check_val("so_0", 32'(b_so), 32'h0);
        tick();
        check_val("so_1", 32'(b_so), 32'h0);
        tick();
        check_val("so_2", 32'(b_so), 32'h1);

        // Full sequence, 2 channels, SI=1, G0..G3=0
        a_start = 1'b1;
        a_si    = 1'b1;
        tick();                             // edge 0
        a_start = 1'b0;
        check_val("seq_hold0", 32'(a_state), 32'h00);
        for (int e = 1; e <= 6; e++) tick();
        check_val("seq_shifted", 32'(a_state), 32'h3F);
        check_val("seq_busy", 32'(a_busy), 32'h1);
        tick();                             // edge 7: launch
        check_val("seq_launch", 32'(a_state), 32'h24);
        check_val("seq_nodone7", 32'(a_done), 32'h0);
        check_val("seq_cap_g17", 32'(a_g17), 32'h3);
        tick();                             // edge 8: capture
        check_val("seq_capture", 32'(a_state), 32'h24);
        check_val("seq_done8", 32'(a_done), 32'h1);
        check_val("seq_misr", 32'(a_misr), 32'(MISR_EXP));
        tick();                             // edge 9
        check_val("seq_done9", 32'(a_done), 32'h0);
        check_val("seq_idle_busy", 32'(a_busy), 32'h0);
        check_val("seq_done_hold", 32'(a_state), 32'h24);

        // START re-asserted during SHIFT is ignored
        a_start = 1'b1;
        tick();                             // edge 0
        a_start = 1'b0;
        done_cnt  = 0;
        done_edge = -1;
        for (int e = 1; e <= 14; e++) begin
            a_start = (e == 2);
            tick();
            if (a_done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
        end
        a_start = 1'b0;
        check_val("restart_done_edge", 32'(done_edge), 32'd8);
        check_val("restart_done_cnt",  32'(done_cnt),  32'd1);

        // Reset during shift cycle 3 aborts the sequence
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        a_rstn = 1'b0;
        #2;
        check_val("abort_state", 32'(a_state), 32'h00);
        check_val("abort_busy",  32'(a_busy),  32'h0);
        check_val("abort_done",  32'(a_done),  32'h0);
        check_val("abort_misr",  32'(a_misr),  32'h0);
        a_rstn = 1'b1;
        done_cnt = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (a_done) done_cnt++;
        end
        check_val("abort_no_done", 32'(done_cnt), 32'd0);
        check_val("abort_idle_state", 32'(a_state), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
